// File: rtl/inv_pkg.sv
// Shared constants and types for the 4-bit inverter datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inv_pkg;

    localparam int INV_WIDTH      = 4;
    localparam int INV_FIFO_DEPTH = 4;

    typedef logic [INV_WIDTH-1:0] nibble_t;

endpackage

// File: rtl/inv_out_fifo_ptr.sv
// Wrapping FIFO pointer: increments modulo 2**W on inc, clears on clr.
// Latency: new value visible the cycle after the enabling edge.
// Backpressure: none; the caller qualifies inc.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over inc
//   inc        : advance the pointer by one
//   ptr        : current pointer value
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Wrap is implicit: the depth is a power of two, so overflow is modulo.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/inv_out_fifo.sv
// First-word-fall-through buffer behind the combinational inverter.
// Latency: 1 cycle from push edge to out_valid; no same-cycle bypass.
// Backpressure: in_ready = !full, from registered state only (never from out_ready).
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous clear of all entries, beats push/pop
//   in_valid/in_ready    : upstream handshake, in_data sampled on push
//   out_valid/out_ready  : downstream handshake, out_data = oldest word (0 when empty)
//   count/full/empty     : occupancy status decoded from the registered count
module inv_out_fifo
    import inv_pkg::*;
#(
    parameter int WIDTH = INV_WIDTH,
    parameter int DEPTH = INV_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flush drops whatever is offered or taken in its cycle.
    assign wr_en = push & ~flush;
    assign rd_en = pop & ~flush;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset; the empty gate on out_data hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= in_data;
        end
    end

    assign out_data = empty ? '0 : mem_q[rd_ptr];
    assign count    = count_q;

endmodule

// File: tb/tb_inv_out_fifo.sv
// Directed bench for inv_out_fifo: inputs change and outputs are sampled at
// the falling edge, so each tick() covers exactly one rising edge.
module tb_inv_out_fifo;
    import inv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    nibble_t    in_data;
    logic       out_valid;
    logic       out_ready;
    nibble_t    out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int vec_cnt = 0;
    int err_cnt = 0;

    inv_out_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [31:0] c, input logic [31:0] d);
        chk({tag, " count"}, 32'(count), c);
        chk({tag, " data"}, 32'(out_data), d);
        chk({tag, " out_valid"}, 32'(out_valid), (c != 0) ? 32'd1 : 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), (c != 4) ? 32'd1 : 32'd0);
    endtask

    initial begin
        nibble_t a;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h5;
        out_ready = 1'b0;

        // Reset held for three edges while a word is offered.
        repeat (3) tick();
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset assertion between edges.
        rst_n    = 1'b1;
        in_data  = 4'hB;
        tick();
        in_valid = 1'b0;
        chk_status("async pre", 1, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async count", 32'(count), 32'd0);
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;

        // Inverter chain: a = 0..15 through ~a, streaming.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = ~4'h0;
        #1 chk("chain no bypass", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            a       = nibble_t'(i);
            in_data = ~a;
            tick();
            chk("chain count", 32'(count), 32'd1);
            chk("chain data", 32'(out_data), 32'(4'hF - a));
        end
        in_valid = 1'b0;
        tick();
        chk("chain drained", 32'(empty), 32'd1);

        // Fill to full under back-pressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'hA; tick();
        in_data = 4'h5; tick();
        in_data = 4'hF; tick();
        in_data = 4'h0; tick();
        chk_status("fill", 4, 32'hA);
        chk("fill full", 32'(full), 32'd1);
        in_data = 4'h3; tick();
        chk_status("full hold", 4, 32'hA);
        out_ready = 1'b1;
        tick();
        chk_status("pop at full", 3, 32'h5);
        tick();
        in_valid = 1'b0;
        chk_status("reaccept", 3, 32'hF);
        tick(); chk_status("drain0", 2, 32'h0);
        tick(); chk_status("drain3", 1, 32'h3);
        tick(); chk_status("drain empty", 0, 32'h0);

        // Simultaneous push/pop at count 2 for 10 cycles, pointers wrap.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        chk_status("pp prime", 2, 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = nibble_t'(k + 3);
            tick();
            chk_status("pp", 2, 32'(k + 2));
        end
        in_valid = 1'b0;
        tick(); chk_status("pp drain", 1, 32'hC);
        tick(); chk_status("pp empty", 0, 32'h0);

        // Flush with a word on offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        in_data = 4'h3; tick();
        chk_status("pre flush", 3, 32'h1);
        flush   = 1'b1;
        in_data = 4'h7;
        tick();
        flush = 1'b0;
        chk_status("flush", 0, 32'h0);
        chk("flush empty", 32'(empty), 32'd1);
        in_data = 4'h9;
        tick();
        in_valid = 1'b0;
        chk_status("post flush", 1, 32'h9);
        out_ready = 1'b1;
        tick(); chk_status("post flush pop", 0, 32'h0);

        // Reset mid-stream discards stored words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'hC; tick();
        in_data = 4'hD; tick();
        in_valid = 1'b0;
        chk_status("mid", 2, 32'hC);
        rst_n = 1'b0;
        #1 chk("mid rst empty", 32'(empty), 32'd1);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h1;
        tick();
        in_valid = 1'b0;
        chk_status("mid first", 1, 32'h1);
        out_ready = 1'b1;
        tick(); chk_status("mid pop", 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
